// File: rtl/sync_edge_filter_if.sv
// rtl/sync_edge_filter_if.sv - din/evt_clr inputs and filtered level, pulse and event outputs
interface sync_edge_filter_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             evt_clr;
  logic             level_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] evt_cnt;
  logic             evt_ovf;

  modport master (
    output din, evt_clr,
    input  level_out, rise_pulse, fall_pulse, evt_cnt, evt_ovf
  );

  modport slave (
    input  din, evt_clr,
    output level_out, rise_pulse, fall_pulse, evt_cnt, evt_ovf
  );
endinterface

// File: rtl/sync_edge_filter.sv
// rtl/sync_edge_filter.sv - stability filter, edge pulses and saturating edge counter on clk_tx
module sync_edge_filter #(
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8,
  parameter int EDGE_SEL    = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic              clk_tx,
  input  logic              rst_tx,
  sync_edge_filter_if.slave bus
);
  localparam int FW = (FILT_CYCLES < 1) ? 1 : $clog2(FILT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] CHK_HI    = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] CHK_LO    = 2'd3;
  localparam logic [1:0] RST_STATE = RST_VAL ? STABLE_HI : STABLE_LO;

  // Out-of-range EDGE_SEL values fall through to counting both edges.
  localparam bit CNT_RISE = (EDGE_SEL != 1);
  localparam bit CNT_FALL = (EDGE_SEL != 0);

  logic [1:0]       state, state_nxt;
  logic [FW-1:0]    fcnt, fcnt_nxt, fcnt_inc;
  logic             acc_rise, acc_fall, counted;
  logic             level_q, rise_q, fall_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    fcnt_inc  = fcnt + 1'b1;
    acc_rise  = 1'b0;
    acc_fall  = 1'b0;
    case (state)
      STABLE_LO: if (bus.din) begin
        if (FILT_CYCLES == 1) begin
          acc_rise  = 1'b1;
          state_nxt = STABLE_HI;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt  = FW'(1);
          state_nxt = CHK_HI;
        end
      end
      CHK_HI: begin
        if (!bus.din) begin
          state_nxt = STABLE_LO;
          fcnt_nxt  = '0;
        end else if (fcnt_inc == FILT_LAST) begin
          acc_rise  = 1'b1;
          state_nxt = STABLE_HI;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt_inc;
        end
      end
      STABLE_HI: if (!bus.din) begin
        if (FILT_CYCLES == 1) begin
          acc_fall  = 1'b1;
          state_nxt = STABLE_LO;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt  = FW'(1);
          state_nxt = CHK_LO;
        end
      end
      CHK_LO: begin
        if (bus.din) begin
          state_nxt = STABLE_HI;
          fcnt_nxt  = '0;
        end else if (fcnt_inc == FILT_LAST) begin
          acc_fall  = 1'b1;
          state_nxt = STABLE_LO;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt_inc;
        end
      end
      default: begin
        state_nxt = RST_STATE;
        fcnt_nxt  = '0;
      end
    endcase
  end

  assign counted = (acc_rise && CNT_RISE) || (acc_fall && CNT_FALL);

  always_ff @(posedge clk_tx or posedge rst_tx) begin
    if (rst_tx) begin
      state   <= RST_STATE;
      fcnt    <= '0;
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      fcnt   <= fcnt_nxt;
      rise_q <= acc_rise;
      fall_q <= acc_fall;
      if (acc_rise)
        level_q <= 1'b1;
      else if (acc_fall)
        level_q <= 1'b0;
      // Clear takes priority, then a same-cycle counted edge is applied on top.
      if (bus.evt_clr) begin
        cnt_q <= counted ? CNT_W'(1) : '0;
        ovf_q <= 1'b0;
      end else if (counted) begin
        if (&cnt_q)
          ovf_q <= 1'b1;
        else
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always @(posedge clk_tx) begin
    assert (FILT_CYCLES >= 1) else $error("sync_edge_filter: FILT_CYCLES must be >= 1");
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.evt_cnt    = cnt_q;
  assign bus.evt_ovf    = ovf_q;
endmodule

// File: tb/tb_sync_edge_filter.sv
// tb/tb_sync_edge_filter.sv - directed checks of sync_edge_filter across several parameter sets
module tb_sync_edge_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sync_edge_filter_if #(.CNT_W(8)) if0 ();
  sync_edge_filter_if #(.CNT_W(8)) if1 ();
  sync_edge_filter_if #(.CNT_W(8)) if2 ();
  sync_edge_filter_if #(.CNT_W(2)) if3 ();

  sync_edge_filter #(.FILT_CYCLES(4), .CNT_W(8), .EDGE_SEL(2), .RST_VAL(1'b0)) u0 (
    .clk_tx(clk), .rst_tx(rst), .bus(if0));
  sync_edge_filter #(.FILT_CYCLES(1), .CNT_W(8), .EDGE_SEL(2), .RST_VAL(1'b0)) u1 (
    .clk_tx(clk), .rst_tx(rst), .bus(if1));
  sync_edge_filter #(.FILT_CYCLES(1), .CNT_W(8), .EDGE_SEL(0), .RST_VAL(1'b0)) u2 (
    .clk_tx(clk), .rst_tx(rst), .bus(if2));
  sync_edge_filter #(.FILT_CYCLES(1), .CNT_W(2), .EDGE_SEL(0), .RST_VAL(1'b0)) u3 (
    .clk_tx(clk), .rst_tx(rst), .bus(if3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if0.level_out !== 1'b0) begin errors++; $display("FAIL reset_level got=%b exp=0", if0.level_out); end
    checks++;
    if ({if0.rise_pulse, if0.fall_pulse} !== 2'b00) begin
      errors++; $display("FAIL reset_pulses got=%b exp=00", {if0.rise_pulse, if0.fall_pulse});
    end
    checks++;
    if (if0.evt_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", if0.evt_cnt); end
    checks++;
    if (if0.evt_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", if0.evt_ovf); end
    rst = 1'b0;
    step();
    if0.din = 1'b1;
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({if0.level_out, if0.rise_pulse} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_chk got=%b exp=00", {if0.level_out, if0.rise_pulse});
    end
    step();
    step();
    if0.din = 1'b0;
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({if0.level_out, if0.rise_pulse, if0.evt_cnt} !== 10'd0) begin
      errors++; $display("FAIL reset_after_mid got=%b exp=0", {if0.level_out, if0.rise_pulse, if0.evt_cnt});
    end
  endtask

  task automatic test_rise();
    if0.din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({if0.level_out, if0.rise_pulse} !== 2'b00) begin
        errors++; $display("FAIL rise_early step=%0d got=%b exp=00", i, {if0.level_out, if0.rise_pulse});
      end
    end
    step();
    checks++;
    if ({if0.level_out, if0.rise_pulse, if0.fall_pulse} !== 3'b110) begin
      errors++; $display("FAIL rise_accept got=%b exp=110", {if0.level_out, if0.rise_pulse, if0.fall_pulse});
    end
    checks++;
    if (if0.evt_cnt !== 8'd1) begin errors++; $display("FAIL rise_cnt got=%0d exp=1", if0.evt_cnt); end
    step();
    checks++;
    if ({if0.level_out, if0.rise_pulse} !== 2'b10) begin
      errors++; $display("FAIL rise_pulse_width got=%b exp=10", {if0.level_out, if0.rise_pulse});
    end
  endtask

  task automatic test_glitch_hi();
    logic seen;
    seen = 1'b0;
    if0.din = 1'b0;
    step();
    seen |= if0.fall_pulse | if0.rise_pulse;
    if0.din = 1'b1;
    repeat (6) begin step(); seen |= if0.fall_pulse | if0.rise_pulse; end
    if0.din = 1'b0;
    repeat (3) begin step(); seen |= if0.fall_pulse | if0.rise_pulse; end
    if0.din = 1'b1;
    repeat (6) begin step(); seen |= if0.fall_pulse | if0.rise_pulse; end
    checks++;
    if ({if0.level_out, seen, if0.evt_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      errors++; $display("FAIL glitch_hi level=%b pulse_seen=%b cnt=%0d exp level=1 pulse_seen=0 cnt=1",
                         if0.level_out, seen, if0.evt_cnt);
    end
  endtask

  task automatic test_fall();
    if0.din = 1'b0;
    repeat (3) step();
    checks++;
    if (if0.level_out !== 1'b1) begin errors++; $display("FAIL fall_early got=%b exp=1", if0.level_out); end
    step();
    checks++;
    if ({if0.level_out, if0.rise_pulse, if0.fall_pulse, if0.evt_cnt} !== {3'b001, 8'd2}) begin
      errors++; $display("FAIL fall_accept level=%b rise=%b fall=%b cnt=%0d exp 0 0 1 2",
                         if0.level_out, if0.rise_pulse, if0.fall_pulse, if0.evt_cnt);
    end
    step();
    checks++;
    if (if0.fall_pulse !== 1'b0) begin errors++; $display("FAIL fall_pulse_width got=%b exp=0", if0.fall_pulse); end
  endtask

  task automatic test_glitch_lo();
    logic seen;
    seen = 1'b0;
    if0.din = 1'b1;
    repeat (3) begin step(); seen |= if0.fall_pulse | if0.rise_pulse; end
    if0.din = 1'b0;
    repeat (6) begin step(); seen |= if0.fall_pulse | if0.rise_pulse; end
    checks++;
    if ({if0.level_out, seen, if0.evt_cnt} !== {1'b0, 1'b0, 8'd2}) begin
      errors++; $display("FAIL glitch_lo level=%b pulse_seen=%b cnt=%0d exp level=0 pulse_seen=0 cnt=2",
                         if0.level_out, seen, if0.evt_cnt);
    end
  endtask

  task automatic test_filt1();
    int rises, falls;
    logic exp_lvl;
    rises = 0;
    falls = 0;
    exp_lvl = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_lvl = ~exp_lvl;
      if1.din = exp_lvl;
      if2.din = exp_lvl;
      step();
      checks++;
      if ({if1.level_out, if1.rise_pulse, if1.fall_pulse} !== {exp_lvl, exp_lvl, ~exp_lvl}) begin
        errors++; $display("FAIL filt1_follow i=%0d got=%b exp=%b", i,
                           {if1.level_out, if1.rise_pulse, if1.fall_pulse}, {exp_lvl, exp_lvl, ~exp_lvl});
      end
      rises += int'(if1.rise_pulse);
      falls += int'(if1.fall_pulse);
      step();
      rises += int'(if1.rise_pulse);
      falls += int'(if1.fall_pulse);
    end
    checks++;
    if (rises != 3 || falls != 3) begin
      errors++; $display("FAIL filt1_pulses rises=%0d falls=%0d exp 3 3", rises, falls);
    end
    checks++;
    if (if1.evt_cnt !== 8'd6) begin errors++; $display("FAIL filt1_cnt_both got=%0d exp=6", if1.evt_cnt); end
    checks++;
    if (if2.evt_cnt !== 8'd3) begin errors++; $display("FAIL filt1_cnt_rise got=%0d exp=3", if2.evt_cnt); end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_cnt;
    logic       exp_ovf;
    for (int i = 1; i <= 5; i++) begin
      exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
      exp_ovf = (i >= 4);
      if3.din = 1'b1;
      step();
      checks++;
      if ({if3.evt_cnt, if3.evt_ovf} !== {exp_cnt, exp_ovf}) begin
        errors++; $display("FAIL ovf_edge%0d cnt=%0d ovf=%b exp cnt=%0d ovf=%b",
                           i, if3.evt_cnt, if3.evt_ovf, exp_cnt, exp_ovf);
      end
      if3.din = 1'b0;
      step();
    end
  endtask

  task automatic test_clr();
    if3.din = 1'b1;
    if3.evt_clr = 1'b1;
    step();
    checks++;
    if ({if3.evt_cnt, if3.evt_ovf} !== {2'd1, 1'b0}) begin
      errors++; $display("FAIL clr_with_edge cnt=%0d ovf=%b exp cnt=1 ovf=0", if3.evt_cnt, if3.evt_ovf);
    end
    step();
    checks++;
    if ({if3.evt_cnt, if3.evt_ovf} !== {2'd0, 1'b0}) begin
      errors++; $display("FAIL clr_alone cnt=%0d ovf=%b exp cnt=0 ovf=0", if3.evt_cnt, if3.evt_ovf);
    end
    if3.evt_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({if0.evt_cnt, if2.evt_cnt, if3.level_out} !== {8'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL async_reset cnt0=%0d cnt2=%0d lvl3=%b exp 0 0 0",
                         if0.evt_cnt, if2.evt_cnt, if3.level_out);
    end
  endtask

  initial begin
    if0.din = 1'b0; if0.evt_clr = 1'b0;
    if1.din = 1'b0; if1.evt_clr = 1'b0;
    if2.din = 1'b0; if2.evt_clr = 1'b0;
    if3.din = 1'b0; if3.evt_clr = 1'b0;
    test_reset();
    test_rise();
    test_glitch_hi();
    test_fall();
    test_glitch_lo();
    test_filt1();
    test_overflow();
    test_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_edge_filter.md
Name: sync_edge_filter

Overview:
- Consumes the single-bit output of the two-flop synchronizer, in the destination (clk_tx) domain.
- Applies a stability (glitch) filter to produce a clean level.
- Generates single-cycle rise and fall pulses.
- Keeps a saturating event counter with sticky overflow for software and debug visibility.
- Sits directly downstream of the synchronizer output. Runs on clk_tx only.

Parameters:
FILT_CYCLES, 4, consecutive identical samples required to accept a level change; legal range >=1
CNT_W, 8, width of evt_cnt
EDGE_SEL, 2, edges counted: 0 = rising only, 1 = falling only, 2 = both
RST_VAL, 0, reset value of level_out (0 or 1)

Ports:
clk_tx  input  1  sole clock
rst_tx  input  1  asynchronous, active-high reset
din  input  1  synchronized level from the synchronizer output; already in the clk_tx domain
evt_clr  input  1  synchronous clear of evt_cnt and evt_ovf
level_out  output  1  filtered level
rise_pulse  output  1  one-cycle pulse on an accepted 0->1 change
fall_pulse  output  1  one-cycle pulse on an accepted 1->0 change
evt_cnt  output  CNT_W  saturating count of selected accepted edges
evt_ovf  output  1  sticky flag: a counted edge occurred while evt_cnt was saturated

Behaviour:
- Interface: one clock, clk_tx. Reset rst_tx is asynchronous and active-high.
- Reset values:
  - level_out = RST_VAL.
  - rise_pulse = fall_pulse = 0.
  - evt_cnt = 0, evt_ovf = 0.
  - Filter counter = 0.
  - FSM = STABLE_LO if RST_VAL = 0, else STABLE_HI.
- Reset assertion takes effect immediately, including mid-filter; all progress is discarded.
- All outputs are registered. No combinational path from din to any output.
- FSM states and transitions:
  - STABLE_LO (level_out = 0):
    - din = 1: filter counter = 1.
    - If FILT_CYCLES = 1: accept immediately (level_out <= 1, rise_pulse <= 1), go to STABLE_HI.
    - Otherwise go to CHK_HI.
  - CHK_HI:
    - din = 0: go to STABLE_LO, counter = 0. No output change (glitch rejected).
    - din = 1: counter increments. When it reaches FILT_CYCLES: level_out <= 1, rise_pulse <= 1, counter = 0, go to STABLE_HI.
  - STABLE_HI and CHK_LO: mirror images of the above, producing fall_pulse.
- Latency: if din first samples a new value at edge k and holds, level_out and the pulse change at edge k+FILT_CYCLES-1. They are visible after that edge.
- Pulses:
  - Exactly one cycle high per accepted change.
  - rise_pulse and fall_pulse are never high in the same cycle.
  - Back-to-back opposite pulses are FILT_CYCLES cycles apart at minimum.
- Filter counter width is clog2(FILT_CYCLES+1).
- Event counter: a counted edge is an accepted edge matching EDGE_SEL.
  - On a counted edge: if evt_cnt < 2^CNT_W-1, increment. Otherwise hold at all-ones and set evt_ovf.
  - The counter update occurs in the same cycle the pulse register is set.
  - evt_clr with no event: evt_cnt <= 0, evt_ovf <= 0.
  - evt_clr with a counted edge in the same cycle: evt_cnt <= 1, evt_ovf <= 0 (clear first, then the event).
  - evt_ovf remains set until evt_clr or reset.
- Post-reset: if din differs from RST_VAL after reset release, the change goes through the normal filter and yields a pulse and a count.
- Invalid parameters: EDGE_SEL values other than 0/1/2 behave as 2. FILT_CYCLES = 0 is illegal and flagged by a simulation-time assertion.

Test Plan:
- Reset, FILT_CYCLES=4, din=0 -> level_out=0, pulses=0, evt_cnt=0, evt_ovf=0. Assert rst_tx mid-CHK_HI -> FSM returns to STABLE_LO with no pulse.
- din 0->1 held, first sampled at edge 10 -> level_out=1 and rise_pulse=1 after edge 13 only. rise_pulse=0 after edge 14. evt_cnt=1 (EDGE_SEL=2).
- din high for 3 cycles then low (FILT_CYCLES=4) -> level_out stays 0, no pulse, evt_cnt unchanged. Repeat as a 1-cycle glitch while in STABLE_HI -> level_out stays 1.
- FILT_CYCLES=1, toggle din every 2 cycles, 6 times -> level_out follows din with 1-cycle latency. 3 rise and 3 fall pulses. evt_cnt=6 (EDGE_SEL=2); evt_cnt=3 with EDGE_SEL=0.
- CNT_W=2, 5 accepted rising edges with EDGE_SEL=0 -> evt_cnt=3 after the 3rd edge, evt_ovf=1 after the 4th. Both hold after the 5th.
- evt_clr asserted in the same cycle as an accepted counted edge with evt_ovf=1 -> next cycle evt_cnt=1, evt_ovf=0. evt_clr alone -> evt_cnt=0.
